// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, FSM state type and sprite RAM address helper
package sprite_pkg;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 5;
  localparam int TRANSP_IDX = 0;
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  typedef logic [PIX_W-1:0] pix_t;
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [3:0] frame, input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return ADDR_W'(frame) * ADDR_W'(SPRITE_W * SPRITE_H) + ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  endfunction
endpackage

// File: rtl/sprite_line_fetcher_if.sv
// sprite_line_fetcher_if: read bus to the 1-cycle registered sprite RAM
interface sprite_line_fetcher_if;
  import sprite_pkg::*;
  logic [ADDR_W-1:0] read_address;
  pix_t sprite_data;
  modport master (output read_address, input sprite_data);
  modport slave (input read_address, output sprite_data);
endinterface

// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: SPRITE_W x PIX_W register file, one write port, one async read port
module sprite_line_buffer
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  pix_t             wdata,
  input  logic [COL_W-1:0] raddr,
  output pix_t             rdata
);
  pix_t mem_q [SPRITE_W];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: fetches one sprite row per scanline into a line buffer and serves
// the palette index for the current DrawX one cycle later
module sprite_line_fetcher
  import sprite_pkg::*;
(
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        line_start,
  input  logic [9:0]                  line_y,
  input  logic [9:0]                  sprite_x,
  input  logic [9:0]                  sprite_y,
  input  logic [3:0]                  frame_idx,
  input  logic [9:0]                  DrawX,
  sprite_line_fetcher_if.master       ram,
  output pix_t                        pixel_idx,
  output logic                        pixel_on,
  output logic                        busy
);
  fetch_state_t state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, wcol_q, wcol_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [3:0] frame_q, frame_d;
  logic [9:0] sx_q, sx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, line_valid_q, line_valid_d, pixel_on_q, pixel_on_d;
  pix_t pixel_idx_q, pixel_idx_d, buf_rdata;
  logic [10:0] row, dx_off;
  logic hit, in_span;
  assign row = {1'b0, line_y} - {1'b0, sprite_y};
  assign hit = (line_y >= sprite_y) && (row < 11'(SPRITE_H));
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    frame_d = frame_q;
    sx_d = sx_q;
    addr_d = addr_q;
    we_d = 1'b0;
    wcol_d = col_q;
    line_valid_d = line_valid_q;
    if (line_start) begin
      row_d = row[ROW_W-1:0];
      frame_d = frame_idx;
      sx_d = sprite_x;
      col_d = '0;
      line_valid_d = 1'b0;
      state_d = hit ? FETCH : IDLE;
      addr_d = hit ? fetch_addr(frame_idx, row[ROW_W-1:0], '0) : addr_q;
    end else if (state_q == FETCH) begin
      we_d = 1'b1;
      col_d = col_q + 1'b1;
      state_d = (col_q == COL_W'(SPRITE_W - 1)) ? DRAIN : FETCH;
      addr_d = (col_q == COL_W'(SPRITE_W - 1)) ? addr_q : fetch_addr(frame_q, row_q, col_d);
    end else if (state_q == DRAIN) begin
      state_d = IDLE;
      line_valid_d = 1'b1;
    end
  end
  // a restart squashes the write still in flight from the aborted row
  sprite_line_buffer u_buf (
    .clk   (Clk),
    .we    (we_q && !line_start),
    .waddr (wcol_q),
    .wdata (ram.sprite_data),
    .raddr (dx_off[COL_W-1:0]),
    .rdata (buf_rdata)
  );
  assign dx_off = {1'b0, DrawX} - {1'b0, sx_q};
  assign in_span = line_valid_q && (DrawX >= sx_q) && (dx_off < 11'(SPRITE_W));
  assign pixel_idx_d = in_span ? buf_rdata : '0;
  assign pixel_on_d = in_span && (buf_rdata != pix_t'(TRANSP_IDX));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      col_q <= '0;
      wcol_q <= '0;
      row_q <= '0;
      frame_q <= '0;
      sx_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      line_valid_q <= 1'b0;
      pixel_idx_q <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      wcol_q <= wcol_d;
      row_q <= row_d;
      frame_q <= frame_d;
      sx_q <= sx_d;
      addr_q <= addr_d;
      we_q <= we_d;
      line_valid_q <= line_valid_d;
      pixel_idx_q <= pixel_idx_d;
      pixel_on_q <= pixel_on_d;
    end
  assign ram.read_address = addr_q;
  assign pixel_idx = pixel_idx_q;
  assign pixel_on = pixel_on_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher: directed checks against a RAM model returning mem[a] = a[4:0]
module tb_sprite_line_fetcher;
  import sprite_pkg::*;
  logic Clk = 1'b0, Reset = 1'b1, line_start = 1'b0;
  logic [9:0] line_y = '0, sprite_x = '0, sprite_y = '0, DrawX = '0;
  logic [3:0] frame_idx = '0;
  pix_t pixel_idx;
  logic pixel_on, busy;
  int n_cmp = 0, n_bad = 0;
  sprite_line_fetcher_if ram();
  sprite_line_fetcher dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_idx(frame_idx), .DrawX(DrawX),
    .ram(ram), .pixel_idx(pixel_idx), .pixel_on(pixel_on), .busy(busy)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) ram.sprite_data <= ram.read_address[4:0];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic start_line(input int y, input int sx, input int sy, input int fr);
    @(negedge Clk);
    line_y = 10'(y); sprite_x = 10'(sx); sprite_y = 10'(sy); frame_idx = 4'(fr);
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
  endtask
  task automatic walk(input string tag, input int base);
    for (int c = 0; c < 16; c++) begin
      check({tag, " addr"}, 32'(ram.read_address), 32'(base + c));
      check({tag, " busy"}, 32'(busy), 1);
      @(negedge Clk);
    end
    check({tag, " drain busy"}, 32'(busy), 1);
    check({tag, " drain addr hold"}, 32'(ram.read_address), 32'(base + 15));
    @(negedge Clk);
    check({tag, " done busy"}, 32'(busy), 0);
  endtask
  task automatic px(input string tag, input int dx, input int idx, input int on);
    DrawX = 10'(dx);
    @(negedge Clk);
    check({tag, " idx"}, 32'(pixel_idx), 32'(idx));
    check({tag, " on"}, 32'(pixel_on), 32'(on));
  endtask
  initial begin
    #1;
    check("reset addr", 32'(ram.read_address), 0);
    check("reset busy", 32'(busy), 0);
    check("reset on", 32'(pixel_on), 0);
    check("reset idx", 32'(pixel_idx), 0);
    @(negedge Clk);
    Reset = 1'b0;
    // basic row: row 3 of frame 0 -> 48..63
    start_line(103, 50, 100, 0);
    walk("t2", 48);
    px("t2 x+2", 52, 18, 1);
    px("t2 x+0", 50, 16, 1);
    px("t2 x+15", 65, 31, 1);
    px("t2 x-1", 49, 0, 0);
    px("t2 x+16", 66, 0, 0);
    // frame 2, top row -> 512.., entry 0 is transparent
    start_line(40, 100, 40, 2);
    walk("t3", 512);
    px("t3 transp", 100, 0, 0);
    px("t3 x+5", 105, 5, 1);
    // misses: no reads, line cleared
    start_line(39, 100, 40, 1);
    check("t4a busy", 32'(busy), 0);
    check("t4a addr", 32'(ram.read_address), 527);
    px("t4a x+5", 105, 0, 0);
    px("t4a x+1", 101, 0, 0);
    start_line(56, 100, 40, 1);
    check("t4b busy", 32'(busy), 0);
    check("t4b addr", 32'(ram.read_address), 527);
    px("t4b x+5", 105, 0, 0);
    // right-edge clip: frame 1 row 5 -> base 336, entry c = 16+c
    start_line(205, 630, 200, 1);
    walk("t5", 336);
    px("t5 630", 630, 16, 1);
    px("t5 639", 639, 25, 1);
    px("t5 629", 629, 0, 0);
    for (int x = 0; x < 6; x++) px("t5 wrap", x, 0, 0);
    // restart 6 cycles into a fetch: row 4 must replace row 3
    start_line(103, 50, 100, 0);
    DrawX = 10'd52;
    for (int c = 0; c < 6; c++) begin
      check("t6 pre addr", 32'(ram.read_address), 32'(48 + c));
      check("t6 pre on", 32'(pixel_on), 0);
      @(negedge Clk);
    end
    line_y = 10'd104; line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) check("t6 addr", 32'(ram.read_address), 32'(64 + c));
      check("t6 stale on", 32'(pixel_on), 0);
      @(negedge Clk);
    end
    px("t6 x+2", 52, 2, 1);
    px("t6 x+0", 50, 0, 0);
    px("t6 x+15", 65, 15, 1);
    // reset mid-fetch at col 5, then clean refetch
    start_line(11, 200, 10, 3);
    repeat (5) @(negedge Clk);
    check("t1 col5 addr", 32'(ram.read_address), 32'(784 + 5));
    Reset = 1'b1;
    #1;
    check("t1 rst addr", 32'(ram.read_address), 0);
    check("t1 rst busy", 32'(busy), 0);
    check("t1 rst on", 32'(pixel_on), 0);
    check("t1 rst idx", 32'(pixel_idx), 0);
    @(negedge Clk);
    Reset = 1'b0;
    px("t1 post", 201, 0, 0);
    check("t1 post busy", 32'(busy), 0);
    start_line(11, 200, 10, 3);
    walk("t1", 784);
    px("t1 x+1", 201, 17, 1);
    px("t1 x+15", 215, 31, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
